// File: rtl/fifo_pop_pkg.sv
// Shared constants and types for the pop-side prefetch stage.
package fifo_pop_pkg;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned LAT_MAX   = 2;

    typedef logic [1:0] level_t;

endpackage

// File: rtl/fifo_pop_skid_buf.sv
// Two-entry register buffer with head/tail pointers and an occupancy count.
module fifo_pop_skid_buf
    import fifo_pop_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output level_t           level
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

    logic [width-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    level_t           level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop) begin
                level_q <= level_q + 2'd1;
            end else if (pop && !push) begin
                level_q <= level_q - 2'd1;
            end
        end
    end

    assign head_data = mem_q[head_q];
    assign level     = level_q;

endmodule

// File: rtl/fifo_pop_prefetch.sv
// Pop-side prefetch: issues FIFO pops, tracks RAM read latency, streams captured words.
module fifo_pop_prefetch
    import fifo_pop_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned ram_lat = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_empty,
    output logic             pop_req_n,
    output logic             ram_re,
    input  logic [width-1:0] ram_rd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output level_t           level
);

    logic [ram_lat-1:0] infl_q;
    logic [ram_lat-1:0] infl_d;
    level_t             infl_cnt;
    logic               accept;
    logic               issue;
    logic               capture;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < ram_lat; i++) begin
            infl_cnt = infl_cnt + {1'b0, infl_q[i]};
        end
    end

    assign out_valid = (level != 2'd0);
    assign accept    = out_valid & out_ready;

    // Words committed (buffered + in flight) after this cycle's accept must stay below depth.
    assign issue = !pop_empty && !flush && !rst &&
                   (({1'b0, level} + {1'b0, infl_cnt}) < (3'd2 + {2'b00, accept}));

    assign pop_req_n = ~issue;
    assign ram_re    = issue;
    assign capture   = infl_q[ram_lat-1] & ~flush;

    if (ram_lat == 1) begin : g_lat1
        assign infl_d = issue;
    end else begin : g_latn
        assign infl_d = {infl_q[ram_lat-2:0], issue};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q <= '0;
        end else if (flush) begin
            infl_q <= '0;
        end else begin
            infl_q <= infl_d;
        end
    end

    fifo_pop_skid_buf #(
        .width(width)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (capture),
        .push_data(ram_rd_data),
        .pop      (accept),
        .head_data(out_data),
        .level    (level)
    );

endmodule

// File: tb/tb_fifo_pop_prefetch.sv
// Bench for fifo_pop_prefetch at ram_lat 1 and 2 against a queue-based reference model.
module tb_fifo_pop_prefetch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         out_ready;
    logic [1:0]   pop_empty;
    logic [1:0]   pop_req_n;
    logic [1:0]   ram_re;
    logic [1:0]   out_valid;
    logic [W-1:0] ram_rd_data [2];
    logic [W-1:0] out_data    [2];
    logic [1:0]   level       [2];

    always #5 clk = ~clk;

    fifo_pop_prefetch #(.width(W), .ram_lat(1)) u_lat1 (
        .clk        (clk),
        .rst        (rst),
        .pop_empty  (pop_empty[0]),
        .pop_req_n  (pop_req_n[0]),
        .ram_re     (ram_re[0]),
        .ram_rd_data(ram_rd_data[0]),
        .flush      (flush),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready),
        .out_data   (out_data[0]),
        .level      (level[0])
    );

    fifo_pop_prefetch #(.width(W), .ram_lat(2)) u_lat2 (
        .clk        (clk),
        .rst        (rst),
        .pop_empty  (pop_empty[1]),
        .pop_req_n  (pop_req_n[1]),
        .ram_re     (ram_re[1]),
        .ram_rd_data(ram_rd_data[1]),
        .flush      (flush),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready),
        .out_data   (out_data[1]),
        .level      (level[1])
    );

    // Reference model: buffered words, in-flight words with their arrival cycle.
    int lat [2] = '{1, 2};
    int bq [2][$];
    int fw [2][$];
    int ft [2][$];
    int avail [2];
    int popped [2];
    int delivered [2];
    int first_pop [2];
    int last_pop [2];
    int first_val [2];
    int base_pop [2];
    int base_del [2];
    int cyc;
    int toggle_mode;
    int rel_cyc;
    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int inst, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            bq[i].delete();
            fw[i].delete();
            ft[i].delete();
        end
    endtask

    task automatic mark();
        for (int i = 0; i < 2; i++) begin
            first_pop[i] = -1;
            last_pop[i]  = -1;
            first_val[i] = -1;
            base_pop[i]  = popped[i];
            base_del[i]  = delivered[i];
        end
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            check("rst_pop_req_n", i, 32'(pop_req_n[i]), 32'd1);
            check("rst_ram_re", i, 32'(ram_re[i]), 32'd0);
            check("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
            check("rst_out_data", i, 32'(out_data[i]), 32'd0);
            check("rst_level", i, 32'(level[i]), 32'd0);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check mid-phase, advance the model.
    task automatic step();
        bit iss [2];
        bit acc [2];
        bit arr [2];
        int arr_w [2];
        for (int i = 0; i < 2; i++) begin
            if (toggle_mode != 0) pop_empty[i] = ((cyc % 2) == 1);
            else                  pop_empty[i] = (avail[i] == 0);
            arr[i] = (ft[i].size() != 0) && (ft[i][0] == cyc);
            arr_w[i] = arr[i] ? fw[i][0] : 0;
            ram_rd_data[i] = arr[i] ? W'(arr_w[i]) : W'($urandom);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            acc[i] = (bq[i].size() != 0) && out_ready;
            iss[i] = !pop_empty[i] && !flush && !rst &&
                     ((bq[i].size() + ft[i].size() - int'(acc[i])) < 2);
            check("pop_req_n", i, 32'(pop_req_n[i]), 32'(!iss[i]));
            check("ram_re", i, 32'(ram_re[i]), 32'(iss[i]));
            check("out_valid", i, 32'(out_valid[i]), 32'(bq[i].size() != 0));
            check("level", i, 32'(level[i]), 32'(bq[i].size()));
            if (bq[i].size() != 0) check("out_data", i, 32'(out_data[i]), 32'(bq[i][0]));
            if (arr[i] && !flush)
                check("capture_room", i, 32'(bq[i].size() < 2 || acc[i]), 32'd1);
            if (iss[i] && first_pop[i] < 0) first_pop[i] = cyc;
            if (iss[i]) last_pop[i] = cyc;
            if (out_valid[i] && first_val[i] < 0) first_val[i] = cyc;
            if (flush || rst) begin
                bq[i].delete();
                fw[i].delete();
                ft[i].delete();
            end else begin
                if (acc[i]) begin
                    void'(bq[i].pop_front());
                    delivered[i]++;
                end
                if (arr[i]) begin
                    bq[i].push_back(arr_w[i]);
                    void'(fw[i].pop_front());
                    void'(ft[i].pop_front());
                end
                if (iss[i]) begin
                    fw[i].push_back(int'($urandom_range(0, 255)));
                    ft[i].push_back(cyc + lat[i]);
                    popped[i]++;
                    if (avail[i] > 0) avail[i]--;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        pop_empty = 2'b11;
        ram_rd_data[0] = '0;
        ram_rd_data[1] = '0;
        cyc = 0;
        toggle_mode = 0;
        for (int i = 0; i < 2; i++) begin
            avail[i] = 0;
            popped[i] = 0;
            delivered[i] = 0;
        end
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // Four words, consumer always ready.
        for (int i = 0; i < 2; i++) avail[i] = 4;
        out_ready = 1'b1;
        mark();
        run(14);
        for (int i = 0; i < 2; i++) begin
            check("t1_latency", i, 32'(first_val[i] - first_pop[i]), 32'(lat[i] + 1));
            check("t1_popped", i, 32'(popped[i] - base_pop[i]), 32'd4);
            check("t1_delivered", i, 32'(delivered[i] - base_del[i]), 32'd4);
        end
        check("t1_back_to_back", 0, 32'(last_pop[0] - first_pop[0]), 32'd3);

        // Backpressure: five words, consumer stalled.
        for (int i = 0; i < 2; i++) avail[i] = 5;
        out_ready = 1'b0;
        mark();
        run(8);
        for (int i = 0; i < 2; i++) begin
            check("t2_popped", i, 32'(popped[i] - base_pop[i]), 32'd2);
            check("t2_level", i, 32'(level[i]), 32'd2);
        end
        out_ready = 1'b1;
        run(16);
        for (int i = 0; i < 2; i++)
            check("t2_delivered", i, 32'(delivered[i] - base_del[i]), 32'd5);

        // Toggling empty flag with random consumer.
        toggle_mode = 1;
        for (int k = 0; k < 80; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        toggle_mode = 0;
        for (int i = 0; i < 2; i++) avail[i] = 0;
        out_ready = 1'b1;
        run(8);
        for (int i = 0; i < 2; i++)
            check("t3_all_delivered", i, 32'(delivered[i]), 32'(popped[i]));

        // Flush with a word buffered and another in flight.
        for (int i = 0; i < 2; i++) avail[i] = 8;
        out_ready = 1'b0;
        run(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t4_level", i, 32'(level[i]), 32'd0);
            check("t4_out_valid", i, 32'(out_valid[i]), 32'd0);
        end
        out_ready = 1'b1;
        mark();
        run(12);
        for (int i = 0; i < 2; i++)
            check("t4_resumed", i, 32'((delivered[i] - base_del[i]) > 0), 32'd1);

        // Asynchronous reset mid-stream, then restart.
        for (int i = 0; i < 2; i++) avail[i] = 20;
        run(6);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        clear_model();
        step();
        rst = 1'b0;
        rel_cyc = cyc;
        mark();
        run(12);
        for (int i = 0; i < 2; i++) begin
            check("t5_first_pop", i, 32'(first_pop[i] - rel_cyc), 32'd0);
            check("t5_latency", i, 32'(first_val[i] - first_pop[i]), 32'(lat[i] + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
